// File: rtl/io_bus_ctrl_pkg.sv
// io_bus_ctrl_pkg: address map, status bit positions and sequencer states for io_bus_ctrl.
package io_bus_ctrl_pkg;

    localparam logic [7:0] UART_DATA = 8'h00;
    localparam logic [7:0] UART_STAT = 8'h01;
    localparam logic [7:0] IO_BASE   = 8'h20;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_AVAIL = 1;
    localparam int STAT_OVR   = 2;

    typedef enum logic [2:0] {IDLE, DECODE, TX_WAIT, TX_STROBE, IO_STROBE, ACK} state_t;

    function automatic logic is_io(input logic [7:0] a);
        return a[7:5] == IO_BASE[7:5];
    endfunction

endpackage

// File: rtl/io_rx_buffer.sv
// io_rx_buffer: UART receive byte buffer with sticky overrun.
// IO_BUS_CTRL_RX_FIFO_EN selects an RX_DEPTH-entry FIFO; otherwise a single holding register.
module io_rx_buffer #(
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       clr_ovr,
    output logic [7:0] dout,
    output logic       empty,
    output logic       overrun
);
`ifdef IO_BUS_CTRL_RX_FIFO_EN
    localparam int D = RX_DEPTH;
`else
    localparam int D = 1;
`endif
    localparam int AW = D > 1 ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          full, do_push, do_pop;

    assign full    = cnt == CW'(D);
    assign empty   = cnt == '0;
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full buffer still lands
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            wp      <= do_push ? (wp == AW'(D - 1) ? '0 : wp + 1'b1) : wp;
            rp      <= do_pop ? (rp == AW'(D - 1) ? '0 : rp + 1'b1) : rp;
            cnt     <= cnt + CW'(do_push) - CW'(do_pop);
            overrun <= (overrun && !clr_ovr) || (push && !do_push);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: byte-bus sequencer for the UART and the IO-register decoder.
// RX buffer depth is chosen by IO_BUS_CTRL_RX_FIFO_EN (FIFO) or left as one holding register.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int TX_TIMEOUT = 1024,
    parameter int RX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_wdata,
    output logic              bus_ack,
    output logic [7:0]        bus_rdata,
    output logic              bus_err,
    output logic [7:0]        uart_denv,
    output logic              uart_wr,
    input  logic              uart_busy,
    input  logic [7:0]        uart_drec,
    input  logic              uart_rx_valid,
    output logic              uart_rd,
    output logic              io_hab,
    output logic [4:0]        io_sel,
    output logic [7:0]        io_data,
    input  logic [7:0]        io_rdata,
    output logic              irq
);
    localparam int CW = $clog2(TX_TIMEOUT + 1);

    state_t        state;
    logic          we_q;
    logic [7:0]    addr_q, wdata_q, rdata_q, rx_dout, status;
    logic [CW-1:0] cnt;
    logic          rx_empty, rx_ovr, pop, clr_ovr, io_rd, bad;

    assign pop     = state == DECODE && !we_q && addr_q == UART_DATA;
    assign clr_ovr = state == DECODE && we_q && addr_q == UART_STAT && wdata_q[STAT_OVR];
    assign io_rd   = !we_q && is_io(addr_q);
    assign bad     = !(addr_q == UART_DATA || addr_q == UART_STAT || is_io(addr_q));
    assign status  = {5'b0, rx_ovr, !rx_empty, uart_busy};
    // IO reads return the mux value live in the ACK cycle; it is captured on leaving ACK
    assign bus_rdata = (state == ACK && io_rd) ? io_rdata : rdata_q;
    assign irq     = !rx_empty;

    io_rx_buffer #(.RX_DEPTH(RX_DEPTH)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (uart_rx_valid),
        .din     (uart_drec),
        .pop     (pop),
        .clr_ovr (clr_ovr),
        .dout    (rx_dout),
        .empty   (rx_empty),
        .overrun (rx_ovr)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            uart_denv <= '0;
            uart_wr   <= 1'b0;
            uart_rd   <= 1'b0;
            io_hab    <= 1'b0;
            io_sel    <= '0;
            io_data   <= '0;
        end else begin
            uart_rd <= uart_rx_valid;
            bus_ack <= 1'b0;
            uart_wr <= 1'b0;
            io_hab  <= 1'b0;
            case (state)
                IDLE: if (bus_req) begin
                    we_q    <= bus_we;
                    addr_q  <= bus_addr[7:0];
                    wdata_q <= bus_wdata;
                    if (is_io(bus_addr[7:0])) begin
                        io_sel  <= bus_addr[4:0];
                        io_data <= bus_wdata;
                    end
                    state <= DECODE;
                end
                DECODE: if (we_q && is_io(addr_q)) begin
                    io_hab <= 1'b1;
                    state  <= IO_STROBE;
                end else if (we_q && addr_q == UART_DATA) begin
                    cnt <= '0;
                    if (uart_busy) state <= TX_WAIT;
                    else begin
                        uart_denv <= wdata_q;
                        uart_wr   <= 1'b1;
                        state     <= TX_STROBE;
                    end
                end else begin
                    bus_ack <= 1'b1;
                    bus_err <= bad || (pop && rx_empty);
                    rdata_q <= (!we_q && addr_q == UART_STAT) ? status : (pop && !rx_empty) ? rx_dout : 8'h00;
                    state   <= ACK;
                end
                TX_WAIT: if (!uart_busy) begin
                    uart_denv <= wdata_q;
                    uart_wr   <= 1'b1;
                    state     <= TX_STROBE;
                end else if (cnt == CW'(TX_TIMEOUT - 1)) begin
                    bus_ack <= 1'b1;
                    bus_err <= 1'b1;
                    rdata_q <= 8'h00;
                    state   <= ACK;
                end else cnt <= cnt + 1'b1;
                TX_STROBE, IO_STROBE: begin
                    bus_ack <= 1'b1;
                    bus_err <= 1'b0;
                    rdata_q <= 8'h00;
                    state   <= ACK;
                end
                ACK: begin
                    if (io_rd) rdata_q <= io_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

endmodule
